// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives the start request and operands; the slave returns the result and status.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, sub, a, b,
    input  out, cout, ovf, busy, done
  );

  modport slave (
    input  en, sub, a, b,
    output out, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, result held until next start.
// Subtraction is a + ~b + 1, so cout is the inverted borrow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             sa;
  logic             sb;
  logic             cout_r;
  logic             ovf_r;
  logic [WIDTH-1:0] b_in;
  logic             start;
  logic             last;
  logic [DIGIT:0]   dsum;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic [DIGIT-1:0] s);
    return (r >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  endfunction

  assign b_in  = bus.sub ? ~bus.b : bus.b;
  assign start = bus.en && (state != CALC);
  assign last  = (state == CALC) && (count == LAST);
  assign dsum  = digit_add(a_reg[DIGIT-1:0], b_reg[DIGIT-1:0], carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = CALC;
      CALC:    if (count == LAST) state_nxt = DONE;
      DONE:    if (bus.en) state_nxt = CALC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CALC);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      count  <= '0;
      carry  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (start) begin
      a_reg  <= bus.a;
      b_reg  <= b_in;
      res    <= '0;
      count  <= '0;
      carry  <= bus.sub;
      sa     <= bus.a[WIDTH-1];
      sb     <= b_in[WIDTH-1];
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == CALC) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      res   <= shift_in(res, dsum[DIGIT-1:0]);
      carry <= dsum[DIGIT];
      count <= last ? count : count + 1'b1;
      if (last) begin
        cout_r <= dsum[DIGIT];
        ovf_r  <= (sa == sb) && (dsum[DIGIT-1] != sa);
      end
    end
  end

  assign bus.out  = res;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four parameterisations, vector table, corner sequences and
// random 16/4 operations, with results predicted into a scoreboard queue.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if0 ();
  serial_addsub_if #(.WIDTH(8))  if1 ();
  serial_addsub_if #(.WIDTH(16)) if2 ();
  serial_addsub_if #(.WIDTH(8))  if3 ();

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  serial_addsub #(.WIDTH(8),  .DIGIT(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
  serial_addsub #(.WIDTH(8),  .DIGIT(8)) u3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    int          idx;
    logic [15:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          idx;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        pulse;
    logic [15:0] out;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wid[4]  = '{8, 8, 16, 8};
  int   ndig[4] = '{8, 4, 4, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic e, input logic s,
                       input logic [15:0] av, input logic [15:0] bv);
    case (idx)
      0: begin if0.en = e; if0.sub = s; if0.a = av[7:0]; if0.b = bv[7:0]; end
      1: begin if1.en = e; if1.sub = s; if1.a = av[7:0]; if1.b = bv[7:0]; end
      2: begin if2.en = e; if2.sub = s; if2.a = av;      if2.b = bv;      end
      default: begin if3.en = e; if3.sub = s; if3.a = av[7:0]; if3.b = bv[7:0]; end
    endcase
  endtask

  task automatic sample(input int idx, output logic [15:0] o, output logic c,
                        output logic v, output logic bz, output logic dn);
    case (idx)
      0: begin o = {8'h0, if0.out}; c = if0.cout; v = if0.ovf; bz = if0.busy; dn = if0.done; end
      1: begin o = {8'h0, if1.out}; c = if1.cout; v = if1.ovf; bz = if1.busy; dn = if1.done; end
      2: begin o = if2.out;         c = if2.cout; v = if2.ovf; bz = if2.busy; dn = if2.done; end
      default: begin o = {8'h0, if3.out}; c = if3.cout; v = if3.ovf; bz = if3.busy; dn = if3.done; end
    endcase
  endtask

  // Whole-word reference: unsigned compare for carry/borrow, signed range for overflow.
  function automatic exp_t ref_model(input int idx, input logic sub,
                                     input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint w, m, ua, ub, full, sa, sbv, r;
    w  = wid[idx];
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (sub) begin full = ua - ub; e.cout = (ua >= ub); end
    else     begin full = ua + ub; e.cout = (full > m);  end
    e.out = 16'(full & m);
    sa  = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sbv = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    r   = sub ? sa - sbv : sa + sbv;
    e.ovf = (r > (longint'(1) << (w - 1)) - 1) || (r < -(longint'(1) << (w - 1)));
    e.idx = idx;
    return e;
  endfunction

  task automatic run_op(input int idx, input logic sub, input logic [15:0] a,
                        input logic [15:0] b, input logic pulse, input exp_t e);
    logic [15:0] o;
    logic        c, v, bz, dn;
    int          busy_cnt;
    int          got;
    exp_t        q;
    sb_q.push_back(e);
    @(negedge clk);
    drive(idx, 1'b1, sub, a, b);
    @(posedge clk); #1;
    drive(idx, 1'b0, sub, a, b);
    sample(idx, o, c, v, bz, dn);
    busy_cnt = bz ? 1 : 0;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (pulse && k == 1) drive(idx, 1'b1, ~sub, 16'h3333, 16'h1111);
      if (pulse && k == 2) drive(idx, 1'b0, sub, a, b);
      sample(idx, o, c, v, bz, dn);
      if (dn) begin got = k; break; end
      if (bz) busy_cnt++;
    end
    if (got == 0) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check("latency", got + 1, ndig[idx] + 1);
      check("busy_cycles", busy_cnt, ndig[idx]);
      check("busy_in_done", {31'd0, bz}, 32'd0);
      if (sb_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
      else begin
        q = sb_q.pop_front();
        check("out",  {16'd0, o}, {16'd0, q.out});
        check("cout", {31'd0, c}, {31'd0, q.cout});
        check("ovf",  {31'd0, v}, {31'd0, q.ovf});
      end
    end
  endtask

  initial begin
    vec_t        vecs[9];
    exp_t        e;
    logic [15:0] o, ra, rb;
    logic        c, v, bz, dn, rs;

    vecs[0] = '{0, 1'b0, 16'd200,   16'd100,   1'b0, 16'd44,    1'b1, 1'b0};
    vecs[1] = '{0, 1'b0, 16'd127,   16'd1,     1'b0, 16'd128,   1'b0, 1'b1};
    vecs[2] = '{0, 1'b1, 16'h0080,  16'h0001,  1'b0, 16'h007F,  1'b1, 1'b1};
    vecs[3] = '{1, 1'b1, 16'd5,     16'd7,     1'b1, 16'h00FE,  1'b0, 1'b0};
    vecs[4] = '{3, 1'b0, 16'h00FF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0};
    vecs[5] = '{1, 1'b0, 16'h007F,  16'h007F,  1'b0, 16'h00FE,  1'b0, 1'b1};
    vecs[6] = '{3, 1'b1, 16'h0000,  16'h0001,  1'b0, 16'h00FF,  1'b0, 1'b0};
    vecs[7] = '{2, 1'b1, 16'h8000,  16'h0001,  1'b0, 16'h7FFF,  1'b1, 1'b1};
    vecs[8] = '{2, 1'b0, 16'hFFFF,  16'hFFFF,  1'b0, 16'hFFFE,  1'b1, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sample(i, o, c, v, bz, dn);
      check("reset_out", {16'd0, o}, 32'd0);
      check("reset_flags", {28'd0, c, v, bz, dn}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      e.idx = vecs[i].idx; e.out = vecs[i].out; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      run_op(vecs[i].idx, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].pulse, e);
    end

    // Result must hold in DONE while en stays low.
    repeat (3) @(posedge clk);
    #1;
    sample(0, o, c, v, bz, dn);
    check("hold_out", {16'd0, o}, 32'h7F);
    check("hold_done", {30'd0, bz, dn}, 32'd1);

    // en held high in DONE restarts every NDIG+1 cycles (NDIG=1 -> alternates).
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 16'd1, 16'd2);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      sample(3, o, c, v, bz, dn);
      check("b2b_state", {30'd0, bz, dn}, (k % 2 == 1) ? 32'd1 : 32'd2);
    end
    drive(3, 1'b0, 1'b0, 16'd1, 16'd2);
    check("b2b_out", {16'd0, o}, 32'd3);

    // Asynchronous reset in the 4th CALC cycle aborts without a done pulse.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd200, 16'd100);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'd200, 16'd100);
    repeat (3) @(posedge clk);
    #2;
    sample(0, o, c, v, bz, dn);
    check("pre_abort_busy", {31'd0, bz}, 32'd1);
    rst = 1'b1;
    #1;
    sample(0, o, c, v, bz, dn);
    check("abort_out", {16'd0, o}, 32'd0);
    check("abort_flags", {28'd0, c, v, bz, dn}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    sample(0, o, c, v, bz, dn);
    check("abort_no_done", {30'd0, bz, dn}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1'b0, 16'h55, 16'h2A, 1'b0, ref_model(0, 1'b0, 16'h55, 16'h2A));

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(2, rs, ra, rb, 1'b0, ref_model(2, rs, ra, rb));
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
